// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants, debt-update action type and clog2 helper for the refresh scheduler
package ram_pkg;

    // 25 MHz system clock x 15.6 us refresh interval
    localparam int unsigned REF_DIV      = 390;
    localparam int unsigned REF_URG_DLY  = 64;
    localparam int unsigned REF_MAX_DEBT = 7;

    // What the owed-refresh counter does on the coming edge
    typedef enum logic [1:0] {
        DEBT_HOLD = 2'd0,
        DEBT_INC  = 2'd1,
        DEBT_DEC  = 2'd2,
        DEBT_SAT  = 2'd3
    } debt_act_e;

    // Bits needed to hold 0..v-1; never less than one bit
    function automatic int clog2(input int unsigned v);
        int          r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ram_refresh_sched_if.sv
// rtl/ram_refresh_sched_if.sv - refresh handshake between scheduler (master) and RAM controller (slave)
interface ram_refresh_sched_if;

    logic RefReq;
    logic RefUrg;
    logic RefAck;
    logic BusIdle;

    modport master (
        output RefReq,
        output RefUrg,
        input  RefAck,
        input  BusIdle
    );

    modport slave (
        input  RefReq,
        input  RefUrg,
        output RefAck,
        output BusIdle
    );

endinterface

// File: rtl/ref_prescaler.sv
// rtl/ref_prescaler.sv - refresh interval divider: holds on !En, one-cycle Tick at DIV-1, Reload restarts interval
module ref_prescaler #(
    parameter int unsigned DIV = 8,
    parameter int unsigned W   = 3
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         En,
    input  logic         Reload,
    output logic         Tick,
    output logic [W-1:0] Count
);

    logic wrap;

    assign wrap = (Count == W'(DIV - 1));

    // A reload pre-pays the interval, so it also swallows a tick landing on the same cycle
    assign Tick = En && wrap && !Reload;

    // Interval counter: reload wins over counting, En=0 freezes the phase
    always_ff @(posedge CLK) begin
        if (RST) begin
            Count <= '0;
        end else if (Reload) begin
            Count <= '0;
        end else if (En) begin
            Count <= wrap ? '0 : Count + W'(1);
        end
    end

endmodule

// File: rtl/ram_refresh_sched.sv
// rtl/ram_refresh_sched.sv - refresh scheduler top: debt counter, urgency timer, RefReq/RefUrg decode (optional REFRESH_IDLE_EN)
module ram_refresh_sched
    import ram_pkg::*;
#(
    parameter int unsigned DIV      = REF_DIV,
    parameter int unsigned URG_DLY  = REF_URG_DLY,
    parameter int unsigned MAX_DEBT = REF_MAX_DEBT,
    parameter int unsigned DEBT_W   = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                En,
    ram_refresh_sched_if.master bus,
    output logic [DEBT_W-1:0]   Debt,
    output logic                Overflow
);

    localparam int PRE_W = clog2(DIV);
    localparam int URG_W = clog2(URG_DLY + 1);

    logic              tick;
    logic              prePay;
    logic [PRE_W-1:0]  preCount;
    logic [URG_W-1:0]  urgCnt;
    logic [URG_W-1:0]  urgNext;
    logic [DEBT_W-1:0] debtNext;
    logic              accAck;
    logic              ovfSet;
    debt_act_e         debtAct;

    ref_prescaler #(
        .DIV (DIV),
        .W   (PRE_W)
    ) u_prescaler (
        .CLK    (CLK),
        .RST    (RST),
        .En     (En),
        .Reload (prePay),
        .Tick   (tick),
        .Count  (preCount)
    );

    assign accAck = bus.RefAck && (Debt != '0);

    // Pick the debt action; a tick and an ack in the same cycle cancel out, even at saturation
    always_comb begin
        debtAct = DEBT_HOLD;
        ovfSet  = 1'b0;
        if (tick && !bus.RefAck) begin
            if (Debt == DEBT_W'(MAX_DEBT)) begin
                debtAct = DEBT_SAT;
                ovfSet  = 1'b1;
            end else begin
                debtAct = DEBT_INC;
            end
        end else if (!tick && accAck) begin
            debtAct = DEBT_DEC;
        end
    end

    // Next debt and urgency timer; the timer restarts whenever a refresh is actually retired
    always_comb begin
        debtNext = Debt;
        case (debtAct)
            DEBT_INC: debtNext = Debt + DEBT_W'(1);
            DEBT_DEC: debtNext = Debt - DEBT_W'(1);
            default:  debtNext = Debt;
        endcase
        urgNext = urgCnt;
        if ((debtNext == '0) || accAck) begin
            urgNext = '0;
        end else if ((Debt != '0) && (urgCnt != URG_W'(URG_DLY))) begin
            urgNext = urgCnt + URG_W'(1);
        end
    end

    // Debt, urgency timer and sticky overflow registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            Debt     <= '0;
            urgCnt   <= '0;
            Overflow <= 1'b0;
        end else begin
            Debt   <= debtNext;
            urgCnt <= urgNext;
            if (ovfSet) begin
                Overflow <= 1'b1;
            end
        end
    end

    assign bus.RefUrg = (Debt != '0) &&
                        ((urgCnt == URG_W'(URG_DLY)) || (Debt >= DEBT_W'(2)));

`ifdef REFRESH_IDLE_EN
    logic earlyWin;

    assign prePay = bus.RefAck && (Debt == '0) && earlyWin;

    // Idle bus in the second half of an interval opens a window to refresh ahead of the tick
    always_ff @(posedge CLK) begin
        if (RST) begin
            earlyWin <= 1'b0;
        end else if (prePay) begin
            earlyWin <= 1'b0;
        end else if ((Debt == '0) && bus.BusIdle && (preCount >= PRE_W'(DIV / 2))) begin
            earlyWin <= 1'b1;
        end else if (Debt != '0) begin
            earlyWin <= 1'b0;
        end
    end

    assign bus.RefReq = (Debt != '0) || earlyWin;
`else
    logic unusedSinks;

    assign prePay      = 1'b0;
    assign unusedSinks = bus.BusIdle ^ (^preCount);
    assign bus.RefReq  = (Debt != '0);
`endif

endmodule

// File: tb/tb_ram_refresh_sched.sv
// tb/tb_ram_refresh_sched.sv - scoreboard bench for ram_refresh_sched (DIV=8, URG_DLY=4, MAX_DEBT=3)
module tb_ram_refresh_sched;

    localparam int DIV  = 8;
    localparam int URG  = 4;
    localparam int MAXD = 3;

    logic       CLK;
    logic       RST;
    logic       En;
    logic [1:0] Debt;
    logic       Overflow;

    ram_refresh_sched_if bus ();

    ram_refresh_sched #(
        .DIV      (DIV),
        .URG_DLY  (URG),
        .MAX_DEBT (MAXD),
        .DEBT_W   (2)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .En       (En),
        .bus      (bus.master),
        .Debt     (Debt),
        .Overflow (Overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int debt;
        int req;
        int urg;
        int ovf;
    } exp_t;

    exp_t sbq[$];
    int   nVec = 0;
    int   nMis = 0;

    int mPre   = 0;
    int mDebt  = 0;
    int mUrg   = 0;
    int mOvf   = 0;
    int mEarly = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit a, input bit idle);
        exp_t x;
        int   tk;
        int   pp;
        int   acc;
        int   nd;
        int   nu;
        int   ne;
        int   np;
        RST         = r;
        En          = e;
        bus.RefAck  = a;
        bus.BusIdle = idle;
        if (r) begin
            np = 0; nd = 0; nu = 0; ne = 0; mOvf = 0;
        end else begin
            pp = 0;
`ifdef REFRESH_IDLE_EN
            pp = (a && mDebt == 0 && mEarly != 0) ? 1 : 0;
`endif
            tk  = (e && mPre == DIV - 1 && pp == 0) ? 1 : 0;
            np  = (pp != 0) ? 0 : (e ? (mPre + 1) % DIV : mPre);
            acc = (a && mDebt > 0) ? 1 : 0;
            nd  = mDebt;
            if (tk != 0 && !a) begin
                if (mDebt == MAXD) mOvf = 1;
                else nd = mDebt + 1;
            end else if (tk == 0 && acc != 0) begin
                nd = mDebt - 1;
            end
            if (nd == 0 || acc != 0) nu = 0;
            else if (mDebt > 0) nu = (mUrg < URG) ? mUrg + 1 : URG;
            else nu = mUrg;
            if (pp != 0) ne = 0;
            else if (mDebt == 0 && idle && mPre >= DIV / 2) ne = 1;
            else if (mDebt != 0) ne = 0;
            else ne = mEarly;
        end
        mPre = np; mDebt = nd; mUrg = nu; mEarly = ne;
        x.debt = nd;
        x.req  = (nd != 0) ? 1 : 0;
`ifdef REFRESH_IDLE_EN
        if (ne != 0) x.req = 1;
`endif
        x.urg = (nd != 0 && (nu == URG || nd >= 2)) ? 1 : 0;
        x.ovf = mOvf;
        sbq.push_back(x);
        @(posedge CLK);
        #1;
        x = sbq.pop_front();
        chk("sb_debt", 32'(Debt), 32'(x.debt));
        chk("sb_req", 32'(bus.RefReq), 32'(x.req));
        chk("sb_urg", 32'(bus.RefUrg), 32'(x.urg));
        chk("sb_ovf", 32'(Overflow), 32'(x.ovf));
    endtask

    task automatic run(input int n, input bit e);
        for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, 1'b0);
    endtask

    initial begin
        RST = 1'b1; En = 1'b0; bus.RefAck = 1'b0; bus.BusIdle = 1'b0;

        // 1: first tick after 8 enabled clocks, urgency 4 clocks later
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_debt", 32'(Debt), 32'd0);
        chk("rst_req", 32'(bus.RefReq), 32'd0);
        chk("rst_urg", 32'(bus.RefUrg), 32'd0);
        chk("rst_ovf", 32'(Overflow), 32'd0);
        run(7, 1'b1);
        chk("t1_debt_pre", 32'(Debt), 32'd0);
        run(1, 1'b1);
        chk("t1_debt", 32'(Debt), 32'd1);
        chk("t1_req", 32'(bus.RefReq), 32'd1);
        run(3, 1'b1);
        chk("t1_urg_wait", 32'(bus.RefUrg), 32'd0);
        run(1, 1'b1);
        chk("t1_urg", 32'(bus.RefUrg), 32'd1);

        // 2: ack two clocks after RefReq rises clears everything
        step(1'b1, 1'b0, 1'b0, 1'b0);
        run(8, 1'b1);
        run(1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t2_debt", 32'(Debt), 32'd0);
        chk("t2_req", 32'(bus.RefReq), 32'd0);
        chk("t2_urg", 32'(bus.RefUrg), 32'd0);

        // 3: saturation and sticky overflow
        step(1'b1, 1'b0, 1'b0, 1'b0);
        run(24, 1'b1);
        chk("t3_sat", 32'(Debt), 32'd3);
        chk("t3_urg", 32'(bus.RefUrg), 32'd1);
        run(7, 1'b1);
        chk("t3_ovf_pre", 32'(Overflow), 32'd0);
        run(1, 1'b1);
        chk("t3_ovf", 32'(Overflow), 32'd1);
        run(8, 1'b1);
        chk("t3_ovf_sticky", 32'(Overflow), 32'd1);
        chk("t3_sat_hold", 32'(Debt), 32'd3);

        // 4: tick coincident with ack leaves debt unchanged, no overflow at max
        step(1'b1, 1'b0, 1'b0, 1'b0);
        run(23, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t4_debt2", 32'(Debt), 32'd2);
        run(8, 1'b1);
        run(7, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t4_debt3", 32'(Debt), 32'd3);
        chk("t4_noovf", 32'(Overflow), 32'd0);

        // 5: reset mid-interval discards debt and restarts the prescaler
        step(1'b1, 1'b0, 1'b0, 1'b0);
        run(19, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t5_debt", 32'(Debt), 32'd0);
        chk("t5_req", 32'(bus.RefReq), 32'd0);
        run(7, 1'b1);
        chk("t5_notick", 32'(Debt), 32'd0);
        run(1, 1'b1);
        chk("t5_tick", 32'(Debt), 32'd1);

        // 6: idle-bus early refresh window
        step(1'b1, 1'b0, 1'b0, 1'b0);
        run(5, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
`ifdef REFRESH_IDLE_EN
        chk("t6_early_req", 32'(bus.RefReq), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t6_prepay_debt", 32'(Debt), 32'd0);
        run(7, 1'b1);
        chk("t6_notick", 32'(Debt), 32'd0);
        run(1, 1'b1);
        chk("t6_tick", 32'(Debt), 32'd1);
`else
        chk("t6_no_early", 32'(bus.RefReq), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t6_ack_ignored", 32'(Debt), 32'd0);
        run(1, 1'b1);
        chk("t6_tick", 32'(Debt), 32'd1);
`endif

        // random traffic including back-to-back acks and En gaps
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 249) == 0),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 1) == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/ram_refresh_sched.md
Name: ram_refresh_sched

Overview:
- Refresh scheduler for the DRAM controller.
- Derives periodic refresh obligations from the system clock and tracks owed refreshes as a saturating debt counter.
- Escalates pending refreshes from normal request to urgent.
- Drives the RAM controller's RefReq/RefUrg inputs; consumes its refresh-start acknowledge.

Parameters:
- DIV, 390, clocks per refresh interval (25 MHz × 15.6 µs); must be ≥ 4.
- URG_DLY, 64, clocks a nonzero debt may wait before RefUrg is forced.
- MAX_DEBT, 7, saturation value of the owed-refresh counter; must be ≥ 2.
- DEBT_W, 3, width of Debt; must hold MAX_DEBT.

Ports:
- CLK, in, 1, system clock; all logic on posedge.
- RST, in, 1, synchronous active-high reset.
- En, in, 1, refresh timebase enable.
- RefAck, in, 1, one-cycle pulse when the RAM controller enters refresh RAS.
- BusIdle, in, 1, CPU bus inactive (no address strobe); used only under the optional feature.
- RefReq, out, 1, refresh requested (opportunistic).
- RefUrg, out, 1, refresh urgent.
- Debt, out, DEBT_W, current owed-refresh count.
- Overflow, out, 1, sticky: a tick arrived while Debt == MAX_DEBT.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock is CLK, reset is RST.
- Reset, on the posedge CLK where RST=1:
  - Prescaler, Debt and UrgCnt clear to 0.
  - Overflow clears.
  - RefReq = 0, RefUrg = 0.
  - Reset mid-operation discards all debt.
- Prescaler:
  - Counts 0..DIV-1 while En=1, then wraps to 0.
  - Tick = En && prescaler == DIV-1, a one-cycle pulse.
  - En=0 holds the prescaler at its value (no ticks); debt still drains via RefAck.
- Debt update, per cycle:
  - Tick only: Debt+1. If Debt == MAX_DEBT it stays at MAX_DEBT and Overflow is set (sticky until RST).
  - RefAck only: Debt−1 if Debt > 0. RefAck at Debt = 0 is ignored (but see optional feature).
  - Tick and RefAck together: Debt unchanged; no Overflow, even at MAX_DEBT.
- UrgCnt:
  - Cleared when the next Debt is 0, or on any accepted RefAck.
  - Otherwise increments while Debt ≠ 0, saturating at URG_DLY.
- Outputs are decoded from registers only; there is no combinational input-to-output path.
  - RefReq = (Debt ≠ 0).
  - RefUrg = (Debt ≠ 0) && (UrgCnt == URG_DLY || Debt ≥ 2).
- Latency: a Tick or RefAck at edge N is visible on Debt/RefReq/RefUrg after edge N (one-register latency).
- Handshake:
  - RefReq/RefUrg stay asserted until enough RefAck pulses drain Debt.
  - A single RefAck retires exactly one refresh.
  - The RAM controller's refresh sequence is ≥4 clocks, so consecutive acks are ≥4 cycles apart. The block must still behave correctly for back-to-back acks.

Optional Feature:
- Macro: REFRESH_IDLE_EN.
- Defined:
  - A registered EarlyWin flag is set when Debt == 0, BusIdle = 1 and prescaler ≥ DIV/2.
  - RefReq = (Debt ≠ 0) || EarlyWin. RefUrg is unchanged.
  - RefAck while Debt == 0 and EarlyWin = 1 pre-pays the current interval: prescaler reloads to 0, no tick is generated that cycle, and EarlyWin clears.
- Undefined: BusIdle is ignored, EarlyWin does not exist, and RefReq = (Debt ≠ 0).

Decomposition:
- Shared package ram_pkg holds:
  - default constants REF_DIV, REF_URG_DLY, REF_MAX_DEBT;
  - a clog2 function used to size the prescaler and UrgCnt.
- One natural sub-module: ref_prescaler. It owns the DIV counter, En hold, Tick generation and the pre-pay reload input.
- Debt, urgency and output decode stay in the top module.

Test Plan:
Bench parameters: DIV=8, URG_DLY=4, MAX_DEBT=3, DEBT_W=2.
1. Reset then En=1 for 8 clocks with no RefAck → Tick on clock 8; Debt=1 and RefReq=1 after that edge; RefUrg=0 until 4 further clocks, then 1.
2. Debt=1, RefAck pulse 2 clocks after RefReq rises → Debt=0, RefReq=0, RefUrg=0 on the next cycle; UrgCnt=0.
3. En=1, no acks for 40 clocks → Debt saturates at 3 after tick 3; Overflow=1 at tick 4 and stays 1; RefUrg=1 once Debt ≥ 2.
4. Debt=2, RefAck coincident with Tick → Debt stays 2, no Overflow. Repeat at Debt=3 → still no Overflow.
5. Debt=2, RST asserted for 1 clock mid-interval → Debt=0, RefReq=0, RefUrg=0, Overflow=0, prescaler restarts from 0.
6. REFRESH_IDLE_EN defined, Debt=0, BusIdle=1 at prescaler=5 → RefReq=1 next cycle; RefAck → prescaler=0, Debt stays 0, next Tick 8 clocks later.
   REFRESH_IDLE_EN undefined, same stimulus → RefReq stays 0; ack ignored.
